// File: rtl/mem_arbiter_if.sv
// Core-side valid/ready ports plus the shared slave bus for mem_arbiter.
// slave: the arbiter's view (serves the cores, drives the bus); master: the environment's view.
interface mem_arbiter_if #(
  parameter int N_PORTS = 4
);
  logic [N_PORTS-1:0]    mem_valid;
  logic [32*N_PORTS-1:0] mem_addr;
  logic [32*N_PORTS-1:0] mem_wdata;
  logic [4*N_PORTS-1:0]  mem_wstrb;
  logic [N_PORTS-1:0]    mem_ready;
  logic [32*N_PORTS-1:0] mem_rdata;
  logic                  s_valid;
  logic [31:0]           s_addr;
  logic [31:0]           s_wdata;
  logic [3:0]            s_wstrb;
  logic                  s_ready;
  logic [31:0]           s_rdata;

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb, s_ready, s_rdata,
    output mem_ready, mem_rdata, s_valid, s_addr, s_wdata, s_wstrb
  );

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb, s_ready, s_rdata,
    input  mem_ready, mem_rdata, s_valid, s_addr, s_wdata, s_wstrb
  );
endinterface

// File: rtl/mem_arbiter.sv
// N-port arbiter onto one shared bus (TDM or round-robin); zero-wait transfer takes 3 cycles.
// Requests wait in mem_valid until granted; slave stalls hold BUSY until s_ready or timeout abort.
module mem_arbiter #(
  parameter int          N_PORTS   = 4,
  parameter int          MODE      = 1,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF,
  localparam int         PORT_BITS = (N_PORTS > 2) ? $clog2(N_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  mem_arbiter_if.slave         bus,
  output logic [PORT_BITS-1:0] grant_id,
  output logic                 bus_err
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t               state, state_nxt;
  logic [PORT_BITS-1:0] slot;
  logic [PORT_BITS-1:0] last;
  logic [PORT_BITS-1:0] pick;
  logic [PORT_BITS-1:0] rr_sel;
  logic                 pick_vld;
  logic                 tmo_hit;
  logic [CW-1:0]        wait_cnt;
  int                   rr_idx;

  // Grant candidate, only consumed in IDLE.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    rr_idx   = 0;
    rr_sel   = '0;
    if (MODE == 0) begin
      pick     = slot;
      pick_vld = bus.mem_valid[slot];
    end else begin
      for (int i = 1; i <= N_PORTS; i++) begin
        rr_idx = (int'(last) + i) % N_PORTS;
        rr_sel = PORT_BITS'(rr_idx);
        if (!pick_vld && bus.mem_valid[rr_sel]) begin
          pick     = rr_sel;
          pick_vld = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: if (pick_vld) state_nxt = BUSY;
      BUSY: begin
        if (bus.s_ready) begin
          state_nxt = RESP;
        end else if (TIMEOUT != 0 && wait_cnt == CW'(TIMEOUT)) begin
          tmo_hit   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.s_valid   <= 1'b0;
      bus.s_addr    <= '0;
      bus.s_wdata   <= '0;
      bus.s_wstrb   <= '0;
      bus.mem_ready <= '0;
      bus.mem_rdata <= '0;
      grant_id      <= '0;
      bus_err       <= 1'b0;
      wait_cnt      <= '0;
      slot          <= '0;
      last          <= PORT_BITS'(N_PORTS - 1);
    end else begin
      bus.mem_ready <= '0;
      bus_err       <= 1'b0;
      case (state)
        IDLE: begin
          // TDM slot moves on every idle cycle so each port's timing ignores others' traffic.
          if (MODE == 0)
            slot <= (slot == PORT_BITS'(N_PORTS - 1)) ? '0 : slot + 1'b1;
          if (pick_vld) begin
            bus.s_addr  <= bus.mem_addr[32*int'(pick) +: 32];
            bus.s_wdata <= bus.mem_wdata[32*int'(pick) +: 32];
            bus.s_wstrb <= bus.mem_wstrb[4*int'(pick) +: 4];
            bus.s_valid <= 1'b1;
            grant_id    <= pick;
            last        <= pick;
            wait_cnt    <= '0;
          end
        end
        BUSY: begin
          if (state_nxt == RESP) begin
            bus.s_valid                          <= 1'b0;
            bus.mem_ready[grant_id]              <= 1'b1;
            bus.mem_rdata[32*int'(grant_id) +: 32] <= bus.s_ready ? bus.s_rdata : ERR_RDATA;
            bus_err                              <= tmo_hit;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: RR instance and TDM instance (both TIMEOUT=4) on one clock/reset.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] rr_gid, tdm_gid;
  logic       rr_err, tdm_err;

  always #5 clk = ~clk;

  mem_arbiter_if #(.N_PORTS(4)) rr_if ();
  mem_arbiter_if #(.N_PORTS(4)) tdm_if ();

  mem_arbiter #(.N_PORTS(4), .MODE(1), .TIMEOUT(4), .ERR_RDATA(32'hDEADBEEF)) dut_rr (
    .clk(clk), .rstn(rstn), .bus(rr_if), .grant_id(rr_gid), .bus_err(rr_err)
  );
  mem_arbiter #(.N_PORTS(4), .MODE(0), .TIMEOUT(4), .ERR_RDATA(32'hDEADBEEF)) dut_tdm (
    .clk(clk), .rstn(rstn), .bus(tdm_if), .grant_id(tdm_gid), .bus_err(tdm_err)
  );

  typedef struct {
    bit          rst;
    logic [3:0]  valid;
    logic        srdy;
    logic [31:0] srdata;
    logic        e_svalid;
    logic [3:0]  e_ready;
    logic [1:0]  e_gid;
    logic        e_err;
    logic [31:0] e_rd;
    bit          chk_all;
    logic [127:0] e_rdall;
  } vec_t;

  vec_t        vq[$];
  int          errs   = 0;
  int          checks = 0;
  logic [31:0] addr_tab [4];
  logic [31:0] wdata_tab [4];
  logic [3:0]  wstrb_tab [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn             = 1'b0;
    rr_if.mem_valid  = '0;
    tdm_if.mem_valid = '0;
    rr_if.s_ready    = 1'b0;
    tdm_if.s_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic add(input bit rst, input logic [3:0] valid, input logic srdy, input logic [31:0] srdata,
                     input logic e_svalid, input logic [3:0] e_ready, input logic [1:0] e_gid,
                     input logic [31:0] e_rd, input bit chk_all, input logic [127:0] e_rdall);
    vec_t v;
    v.rst = rst; v.valid = valid; v.srdy = srdy; v.srdata = srdata;
    v.e_svalid = e_svalid; v.e_ready = e_ready; v.e_gid = e_gid; v.e_err = 1'b0;
    v.e_rd = e_rd; v.chk_all = chk_all; v.e_rdall = e_rdall;
    vq.push_back(v);
  endtask

  task automatic tdm_run(input logic [3:0] v, input int exp_rise, input string tag);
    int rise = -1;
    int idle = 0;
    int idle_at = 0;
    do_reset();
    tdm_if.mem_valid = v;
    tdm_if.s_ready   = 1'b1;
    tdm_if.s_rdata   = 32'h3333_0003;
    for (int c = 0; c < 20; c++) begin
      if (rise < 0 && tdm_if.s_valid && tdm_gid == 2'd3) begin
        rise    = c;
        idle_at = idle;
      end
      if (!tdm_if.s_valid && tdm_if.mem_ready == 4'b0) idle++;
      if (tdm_if.mem_ready[3]) tdm_if.mem_valid[3] = 1'b0;
      tick();
    end
    tdm_if.mem_valid = '0;
    chk({tag, " port3 s_valid cycle"}, rise, exp_rise);
    chk({tag, " port3 slot position"}, (idle_at - 1) % 4, 3);
  endtask

  task automatic tmo_run(input int ready_at, input logic exp_err, input logic [31:0] exp_rd, input string tag);
    int          rdy_c = -1;
    int          pulses = 0;
    logic        err_at = 1'b0;
    logic        err_after = 1'b1;
    logic [3:0]  rdyv = '0;
    logic [31:0] rd_at = '0;
    do_reset();
    rr_if.mem_valid = 4'b0010;
    rr_if.s_rdata   = 32'h600D_F00D;
    for (int c = 0; c < 15; c++) begin
      if (rdy_c >= 0 && c == rdy_c + 1) err_after = rr_err;
      if (rr_if.mem_ready != 4'b0) begin
        pulses++;
        if (rdy_c < 0) begin
          rdy_c  = c;
          err_at = rr_err;
          rd_at  = rr_if.mem_rdata[63:32];
          rdyv   = rr_if.mem_ready;
        end
      end
      rr_if.s_ready = (c == ready_at);
      if (rdy_c >= 0) rr_if.mem_valid = '0;
      tick();
    end
    chk({tag, " mem_ready cycle"}, rdy_c, 6);
    chk({tag, " mem_ready vector"}, rdyv, 4'b0010);
    chk({tag, " bus_err with ready"}, err_at, exp_err);
    chk({tag, " mem_rdata[1]"}, rd_at, exp_rd);
    chk({tag, " bus_err next cycle"}, err_after, 1'b0);
    chk({tag, " ready pulses"}, pulses, 1);
  endtask

  initial begin
    addr_tab  = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0010, 32'h0000_0300};
    wdata_tab = '{32'hAABB_CCDD, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    wstrb_tab = '{4'b0101, 4'b0000, 4'b0000, 4'b0011};
    for (int p = 0; p < 4; p++) begin
      rr_if.mem_addr[32*p +: 32]   = addr_tab[p];
      rr_if.mem_wdata[32*p +: 32]  = wdata_tab[p];
      rr_if.mem_wstrb[4*p +: 4]    = wstrb_tab[p];
      tdm_if.mem_addr[32*p +: 32]  = addr_tab[p];
      tdm_if.mem_wdata[32*p +: 32] = wdata_tab[p];
      tdm_if.mem_wstrb[4*p +: 4]   = wstrb_tab[p];
    end
    rr_if.s_rdata  = '0;
    tdm_if.s_rdata = '0;
    do_reset();

    chk("reset s_valid",   rr_if.s_valid, 1'b0);
    chk("reset s_addr",    rr_if.s_addr, 32'h0);
    chk("reset s_wdata",   rr_if.s_wdata, 32'h0);
    chk("reset s_wstrb",   rr_if.s_wstrb, 4'h0);
    chk("reset mem_ready", rr_if.mem_ready, 4'h0);
    chk("reset mem_rdata", rr_if.mem_rdata, 128'h0);
    chk("reset grant_id",  rr_gid, 2'd0);
    chk("reset bus_err",   rr_err, 1'b0);
    chk("reset tdm s_valid", tdm_if.s_valid, 1'b0);
    chk("reset tdm grant_id", tdm_gid, 2'd0);

    // Single read from port 2, zero-wait slave; valid still high in RESP must not re-grant.
    add(1, 4'b0100, 1, 32'h1234_5678, 0, 4'b0000, 2'd0, 32'h0, 1, 128'h0);
    add(0, 4'b0100, 1, 32'h1234_5678, 1, 4'b0000, 2'd2, 32'h0, 1, 128'h0);
    add(0, 4'b0100, 1, 32'h0,         0, 4'b0100, 2'd2, 32'h1234_5678, 1, {32'h0, 32'h1234_5678, 64'h0});
    add(0, 4'b0000, 1, 32'h0,         0, 4'b0000, 2'd2, 32'h0, 1, {32'h0, 32'h1234_5678, 64'h0});
    add(0, 4'b0000, 1, 32'h0,         0, 4'b0000, 2'd2, 32'h0, 1, {32'h0, 32'h1234_5678, 64'h0});
    // Round-robin fairness, all ports requesting continuously from reset.
    add(1, 4'b1111, 1, 32'h5000_0000, 0, 4'b0000, 2'd0, 32'h0, 0, 128'h0);
    add(0, 4'b1111, 1, 32'h5000_0001, 1, 4'b0000, 2'd0, 32'h0, 0, 128'h0);
    add(0, 4'b1111, 1, 32'h5000_0002, 0, 4'b0001, 2'd0, 32'h5000_0001, 0, 128'h0);
    add(0, 4'b1111, 1, 32'h5000_0003, 0, 4'b0000, 2'd0, 32'h0, 0, 128'h0);
    add(0, 4'b1111, 1, 32'h5000_0004, 1, 4'b0000, 2'd1, 32'h0, 0, 128'h0);
    add(0, 4'b1111, 1, 32'h5000_0005, 0, 4'b0010, 2'd1, 32'h5000_0004, 0, 128'h0);
    add(0, 4'b1111, 1, 32'h5000_0006, 0, 4'b0000, 2'd1, 32'h0, 0, 128'h0);
    add(0, 4'b1111, 1, 32'h5000_0007, 1, 4'b0000, 2'd2, 32'h0, 0, 128'h0);
    add(0, 4'b1111, 1, 32'h5000_0008, 0, 4'b0100, 2'd2, 32'h5000_0007, 0, 128'h0);
    add(0, 4'b1111, 1, 32'h5000_0009, 0, 4'b0000, 2'd2, 32'h0, 0, 128'h0);
    add(0, 4'b1111, 1, 32'h5000_000A, 1, 4'b0000, 2'd3, 32'h0, 0, 128'h0);
    add(0, 4'b1111, 1, 32'h5000_000B, 0, 4'b1000, 2'd3, 32'h5000_000A, 0, 128'h0);
    add(0, 4'b1111, 1, 32'h5000_000C, 0, 4'b0000, 2'd3, 32'h0, 0, 128'h0);
    add(0, 4'b1111, 1, 32'h5000_000D, 1, 4'b0000, 2'd0, 32'h0, 0, 128'h0);
    add(0, 4'b1111, 1, 32'h5000_000E, 0, 4'b0001, 2'd0, 32'h5000_000D, 0, 128'h0);

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].rst) do_reset();
      chk($sformatf("vec%0d s_valid", i),   rr_if.s_valid, vq[i].e_svalid);
      chk($sformatf("vec%0d mem_ready", i), rr_if.mem_ready, vq[i].e_ready);
      chk($sformatf("vec%0d grant_id", i),  rr_gid, vq[i].e_gid);
      chk($sformatf("vec%0d bus_err", i),   rr_err, vq[i].e_err);
      if (vq[i].e_svalid)
        chk($sformatf("vec%0d s_addr", i), rr_if.s_addr, addr_tab[vq[i].e_gid]);
      for (int p = 0; p < 4; p++)
        if (vq[i].e_ready[p])
          chk($sformatf("vec%0d mem_rdata[%0d]", i, p), rr_if.mem_rdata[32*p +: 32], vq[i].e_rd);
      if (vq[i].chk_all)
        chk($sformatf("vec%0d mem_rdata all", i), rr_if.mem_rdata, vq[i].e_rdall);
      rr_if.mem_valid = vq[i].valid;
      rr_if.s_ready   = vq[i].srdy;
      rr_if.s_rdata   = vq[i].srdata;
      tick();
    end
    rr_if.mem_valid = '0;

    tdm_run(4'b1000, 4, "tdm alone");
    tdm_run(4'b1111, 10, "tdm loaded");

    tmo_run(-1, 1'b1, 32'hDEAD_BEEF, "timeout");
    tmo_run(5,  1'b0, 32'h600D_F00D, "ready at limit");

    // Write from port 0 with a 3-cycle slave wait.
    begin
      int sv_cnt = 0;
      int pulses = 0;
      int rdy_c  = -1;
      logic [31:0] rd = '0;
      do_reset();
      rr_if.mem_valid = 4'b0001;
      rr_if.s_rdata   = 32'h7777_0000;
      for (int c = 0; c < 12; c++) begin
        if (rr_if.s_valid) begin
          sv_cnt++;
          chk($sformatf("write c%0d s_wstrb", c), rr_if.s_wstrb, 4'b0101);
          chk($sformatf("write c%0d s_wdata", c), rr_if.s_wdata, 32'hAABB_CCDD);
          chk($sformatf("write c%0d s_addr", c),  rr_if.s_addr, 32'h0000_0100);
        end
        if (rr_if.mem_ready != 4'b0) begin
          pulses++;
          rdy_c = c;
          rd    = rr_if.mem_rdata[31:0];
        end
        rr_if.s_ready = (c == 4);
        if (pulses > 0) rr_if.mem_valid = '0;
        tick();
      end
      chk("write busy cycles", sv_cnt, 4);
      chk("write ready pulses", pulses, 1);
      chk("write ready cycle", rdy_c, 5);
      chk("write mem_rdata[0]", rd, 32'h7777_0000);
    end

    // Asynchronous reset in the middle of a stalled transfer.
    begin
      int seen_rise = -1;
      int stale = 0;
      logic [1:0] gid = 2'd3;
      do_reset();
      rr_if.mem_valid = 4'b0100;
      tick();
      tick();
      chk("arst busy before", rr_if.s_valid, 1'b1);
      #2 rstn = 1'b0;
      #1;
      chk("arst s_valid drop", rr_if.s_valid, 1'b0);
      chk("arst mem_ready", rr_if.mem_ready, 4'b0);
      rr_if.mem_valid = 4'b0101;
      rr_if.s_ready   = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("arst held mem_ready", rr_if.mem_ready, 4'b0);
      #2 rstn = 1'b1;
      for (int c = 0; c < 10; c++) begin
        if (seen_rise < 0 && rr_if.mem_ready != 4'b0) stale++;
        if (seen_rise < 0 && rr_if.s_valid) begin
          seen_rise = c;
          gid       = rr_gid;
        end
        if (rr_if.mem_ready[0]) rr_if.mem_valid[0] = 1'b0;
        if (rr_if.mem_ready[2]) rr_if.mem_valid[2] = 1'b0;
        tick();
      end
      chk("arst first grant cycle", seen_rise, 1);
      chk("arst first grant port", gid, 2'd0);
      chk("arst stale ready", stale, 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised N-port memory arbiter between the PicoRV32 cores and the single shared on-chip bus (BRAM plus LED/UART I/O decode). It replaces the fixed-slot, fixed-four-core look-ahead arbitration with a native valid/ready front end per core. The arbitration policy is selectable: deterministic TDM for lockstep/redundant mcompose modes, or work-conserving round-robin. Downstream-slave timeout is handled with an error response.

## Interface
Parameters:
- N_PORTS, 4: number of core ports (2..8).
- MODE, 1: 0 = TDM slot arbitration, 1 = round-robin.
- TIMEOUT, 255: maximum slave wait cycles before abort; 0 disables the timeout.
- ERR_RDATA, 32'hDEADBEEF: read data returned on timeout.
- PORT_BITS (derived): max(1, $clog2(N_PORTS)).

Ports (clock and reset first):
- clk  in  1  single clock; all logic on posedge.
- rstn  in  1  reset, asynchronous, active-low.
- mem_valid  in  N_PORTS  per-port request; held until that port's mem_ready.
- mem_addr  in  32*N_PORTS  byte address; port p uses [32p+31:32p].
- mem_wdata  in  32*N_PORTS  write data.
- mem_wstrb  in  4*N_PORTS  byte enables; 0 means read.
- mem_ready  out  N_PORTS  one-cycle completion pulse per port.
- mem_rdata  out  32*N_PORTS  per-port read data, valid when mem_ready is high.
- s_valid  out  1  downstream request.
- s_addr  out  32  address of the granted request.
- s_wdata  out  32  write data of the granted request.
- s_wstrb  out  4  byte enables of the granted request.
- s_ready  in  1  slave completion; s_rdata is valid in the same cycle.
- s_rdata  in  32  slave read data.
- grant_id  out  PORT_BITS  currently or last granted port.
- bus_err  out  1  one-cycle pulse on timeout abort.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: choose a port (see policy below).
  - If a port is chosen: latch addr/wdata/wstrb of port g into s_* registers, set grant_id=g, go to BUSY.
  - If no port is chosen: stay in IDLE.
- BUSY: s_valid=1. s_addr, s_wdata and s_wstrb are stable for the whole state.
  - s_ready=1: capture s_rdata, go to RESP.
  - Otherwise wait_cnt increments each cycle.
  - If TIMEOUT!=0 and wait_cnt==TIMEOUT with s_ready=0: capture ERR_RDATA, set err flag, go to RESP.
  - If s_ready arrives in the same cycle the timeout would fire, s_ready wins and there is no error.
- RESP: mem_ready[g]=1 and mem_rdata[g]=captured data. bus_err=err flag. Next state is IDLE. No arbitration takes place in RESP, so a port whose valid is still high in the RESP cycle cannot be double-granted.
- mem_rdata of port g is updated on every completion, including writes (slave data or ERR_RDATA). The other ports' mem_rdata slices are held.
- TDM (MODE=0): slot pointer advances by 1 mod N_PORTS on every IDLE cycle, granted or not. A grant happens only if mem_valid[slot] is high. Each port's access pattern is independent of the other ports' traffic.
- RR (MODE=1): search from last+1 upward with wrap; the first asserted mem_valid is granted and last is set to g. Starvation bound: N_PORTS-1 transfers.
- A requester deasserting mem_valid while in BUSY is a protocol violation. The transfer still completes and mem_ready is still pulsed.

## Timing
- Reset (async assert, sync-to-clk release):
  - state=IDLE, s_valid=0, s_addr/s_wdata/s_wstrb=0.
  - mem_ready=0, mem_rdata=0, grant_id=0, bus_err=0, wait_cnt=0.
  - slot=0, last=N_PORTS-1, so port 0 wins first.
- Reset asserted mid-transfer: s_valid drops immediately and no mem_ready is issued.
- Zero-wait slave: mem_valid sampled in IDLE at cycle 0 → s_valid high in cycle 1 → mem_ready in cycle 2 → IDLE in cycle 3. Peak throughput is one transfer per 3 cycles.
- Each slave wait cycle adds 1 cycle of latency.
- A timeout completes with mem_ready exactly TIMEOUT+1 cycles after the first BUSY cycle.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- Single read, RR, zero-wait slave: port 2 reads 0x0000_0010 and slave returns 0x1234_5678 → s_valid in cycle 1 only; mem_ready[2] and mem_rdata[2]=0x12345678 in cycle 2; other slices stay 0.
- RR fairness: all 4 ports request continuously after reset → grant order 0,1,2,3,0,… with one grant every 3 cycles.
- TDM determinism: MODE=0, only port 3 requests at cycle 0 → grant occurs in the IDLE cycle where slot==3 (cycle 3). Repeat with ports 0–2 also busy → port 3's grant happens at the same slot position.
- Timeout: TIMEOUT=4, slave never asserts s_ready, port 1 reads → mem_ready[1] and bus_err together 5 cycles after the first BUSY cycle, mem_rdata[1]=0xDEADBEEF. Variant with s_ready asserted at wait_cnt==4 → slave data returned, bus_err=0.
- Write: port 0, wstrb=4'b0101, wdata=0xAABBCCDD → s_wstrb=0101 and s_wdata held stable throughout a 3-cycle slave wait; a single mem_ready[0] pulse.
- Async reset asserted mid-BUSY → s_valid=0 in the same cycle; after release the first grant goes to port 0 and no stale mem_ready appears.
